// File: rtl/gmc_pkg.sv
// Shared types and constants for the gated multichannel counter.
package gmc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        LATCH = 2'd2
    } gmc_state_t;

    localparam int SEQ_W = 8;

endpackage

// File: rtl/gmc_channel.sv
// One input channel: synchroniser, rising-edge detect, saturating counter
// with a sticky overflow flag. clr has priority over en.
module gmc_channel #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   edge_seen;

    // Shift the async input through the synchroniser and remember the previous settled level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A 0->1 step at the last synchroniser stage is one edge, presented for exactly one cycle
    assign edge_seen = sync_q[SYNC_STAGES-1] & ~last_q;

    // Saturating count; an edge arriving at full scale sets ovf instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (en && edge_seen) begin
            if (&count) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gated_multichannel_counter.sv
// Gated pulse counter: N_CH channels counted over a programmable window,
// results latched into a snapshot bank with overflow flags and a sequence number.
//
// Control strobes: start and stop are single-cycle strobes sampled on every
// rising clock edge with no back-pressure. start is honoured only in IDLE;
// stop wins over start in the same cycle; stop during LATCH lets the snapshot
// finish. done is a one-cycle pulse during the LATCH cycle; the snapshot bank,
// ovf and seq_no all update together at the end of that cycle.
module gated_multichannel_counter
    import gmc_pkg::*;
#(
    parameter int N_CH        = 32,
    parameter int CNT_W       = 32,
    parameter int GATE_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                    clk,
    input  logic                                    key_restart,
    input  logic [N_CH-1:0]                         cnt_in,
    input  logic [GATE_W-1:0]                       gate_len,
    input  logic                                    repeat_mode,
    input  logic                                    start,
    input  logic                                    stop,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] rd_ch,
    output logic [CNT_W-1:0]                        rd_data,
    output logic [N_CH-1:0]                         ovf,
    output logic                                    busy,
    output logic                                    done,
    output logic [SEQ_W-1:0]                        seq_no,
    output logic [1:0]                              state_dbg
);

    localparam int RD_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [RD_W:0] RD_LIMIT = (RD_W + 1)'(N_CH);

    gmc_state_t        state;
    logic [GATE_W-1:0] gate_cnt;
    logic [GATE_W-1:0] len_q;
    logic              rep_q;

    logic [GATE_W-1:0] len_eff;
    logic              start_ok;
    logic              count_en;
    logic              clr_live;

    logic [CNT_W-1:0]  live_cnt [N_CH];
    logic [N_CH-1:0]   live_ovf;
    logic [CNT_W-1:0]  snap_q   [N_CH];

    // A zero-length gate behaves as a one-cycle gate
    assign len_eff  = (gate_len == '0) ? GATE_W'(1) : gate_len;
    assign start_ok = (state == IDLE) && start && !stop;
    assign count_en = (state == COUNT);
    // Live counters clear at every gate start, including the auto-repeat restart
    assign clr_live = start_ok || ((state == LATCH) && rep_q && !stop);
    assign state_dbg = state;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        gmc_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk      (clk),
            .rst_n    (key_restart),
            .pulse_in (cnt_in[g]),
            .clr      (clr_live),
            .en       (count_en),
            .count    (live_cnt[g]),
            .ovf      (live_ovf[g])
        );
    end

    // Control FSM with gate timer, busy/done and sequence number
    always_ff @(posedge clk or negedge key_restart) begin
        if (!key_restart) begin
            state    <= IDLE;
            gate_cnt <= '0;
            len_q    <= '0;
            rep_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            seq_no   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        gate_cnt <= len_eff;
                        len_q    <= len_eff;
                        rep_q    <= repeat_mode;
                        busy     <= 1'b1;
                        state    <= COUNT;
                    end
                end
                COUNT: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (gate_cnt == GATE_W'(1)) begin
                        done  <= 1'b1;
                        state <= LATCH;
                    end else begin
                        gate_cnt <= gate_cnt - GATE_W'(1);
                    end
                end
                LATCH: begin
                    seq_no <= seq_no + SEQ_W'(1);
                    if (rep_q && !stop) begin
                        gate_cnt <= len_q;
                        state    <= COUNT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Snapshot bank and overflow flags copy the live values only in LATCH
    always_ff @(posedge clk or negedge key_restart) begin
        if (!key_restart) begin
            for (int i = 0; i < N_CH; i++) begin
                snap_q[i] <= '0;
            end
            ovf <= '0;
        end else if (state == LATCH) begin
            for (int i = 0; i < N_CH; i++) begin
                snap_q[i] <= live_cnt[i];
            end
            ovf <= live_ovf;
        end
    end

    // Registered read port; out-of-range channels read as zero
    always_ff @(posedge clk or negedge key_restart) begin
        if (!key_restart) begin
            rd_data <= '0;
        end else if ({1'b0, rd_ch} < RD_LIMIT) begin
            rd_data <= snap_q[rd_ch];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_gated_multichannel_counter.sv
// Bench for gated_multichannel_counter: directed scenarios with literal
// expectations plus a gate-timeline model checked on every cycle.
module tb_gated_multichannel_counter;

    localparam int N_CH   = 24;
    localparam int CNT_W  = 4;
    localparam int GATE_W = 16;
    localparam int SYNC   = 2;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              key_restart;
    logic [N_CH-1:0]   cnt_in;
    logic [GATE_W-1:0] gate_len;
    logic              repeat_mode;
    logic              start;
    logic              stop;
    logic [4:0]        rd_ch;
    logic [CNT_W-1:0]  rd_data;
    logic [N_CH-1:0]   ovf;
    logic              busy;
    logic              done;
    logic [7:0]        seq_no;
    logic [1:0]        state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    gated_multichannel_counter #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .GATE_W      (GATE_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .key_restart (key_restart),
        .cnt_in      (cnt_in),
        .gate_len    (gate_len),
        .repeat_mode (repeat_mode),
        .start       (start),
        .stop        (stop),
        .rd_ch       (rd_ch),
        .rd_data     (rd_data),
        .ovf         (ovf),
        .busy        (busy),
        .done        (done),
        .seq_no      (seq_no),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- gate timeline model ----------------
    // A gate started in cycle s counts in cycles t0..t0+len-1 (t0 = s+1) and
    // latches in cycle t0+len; in repeat mode the pattern recurs every len+1.
    // An input raised in cycle t is seen as an edge in cycle t+SYNC.
    int              cyc = 0;
    bit              m_active;
    bit              m_rep;
    int              m_t0;
    int              m_len;
    int              m_live [N_CH];
    logic [N_CH-1:0] m_lovf;
    int              m_snap [N_CH];
    logic [N_CH-1:0] m_sovf;
    int              m_seq;
    logic [N_CH-1:0] smp_q [$];

    logic             exp_busy = 1'b0;
    logic             exp_done = 1'b0;
    logic [7:0]       exp_seq  = '0;
    logic [N_CH-1:0]  exp_ovf  = '0;
    logic [CNT_W-1:0] exp_rd   = '0;

    // 0 = idle, 1 = counting, 2 = latching
    function automatic int phase_of(input int c);
        int pos;
        if (!m_active || c < m_t0) return 0;
        pos = c - m_t0;
        if (!m_rep && pos > m_len) return 0;
        return ((pos % (m_len + 1)) < m_len) ? 1 : 2;
    endfunction

    function automatic void model_clear();
        m_active = 1'b0;
        m_rep    = 1'b0;
        m_t0     = 0;
        m_len    = 1;
        m_lovf   = '0;
        m_sovf   = '0;
        m_seq    = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_live[i] = 0;
            m_snap[i] = 0;
        end
        smp_q = {};
        for (int i = 0; i <= SYNC; i++) smp_q.push_back('0);
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_seq  = '0;
        exp_ovf  = '0;
        exp_rd   = '0;
    endfunction

    function automatic void model_step();
        int               ph;
        int               ph_n;
        logic [N_CH-1:0]  rises;
        logic [CNT_W-1:0] rd_n;
        ph    = phase_of(cyc);
        rises = smp_q[1] & ~smp_q[0];
        rd_n  = (rd_ch < N_CH) ? CNT_W'(m_snap[rd_ch]) : '0;
        if (ph == 1) begin
            for (int i = 0; i < N_CH; i++) begin
                if (rises[i]) begin
                    if (m_live[i] < MAXC) m_live[i]++;
                    else m_lovf[i] = 1'b1;
                end
            end
        end
        if (ph == 2) begin
            for (int i = 0; i < N_CH; i++) m_snap[i] = m_live[i];
            m_sovf = m_lovf;
            m_seq  = (m_seq + 1) % 256;
        end
        if (ph == 0 && start && !stop) begin
            m_active = 1'b1;
            m_t0     = cyc + 1;
            m_len    = (gate_len == 0) ? 1 : int'(gate_len);
            m_rep    = repeat_mode;
            for (int i = 0; i < N_CH; i++) m_live[i] = 0;
            m_lovf = '0;
        end else if (ph == 1 && stop) begin
            m_active = 1'b0;
        end else if (ph == 2) begin
            if (m_rep && !stop) begin
                for (int i = 0; i < N_CH; i++) m_live[i] = 0;
                m_lovf = '0;
            end else begin
                m_active = 1'b0;
            end
        end
        smp_q.push_back(cnt_in);
        void'(smp_q.pop_front());
        cyc++;
        ph_n     = phase_of(cyc);
        exp_busy = (ph_n != 0);
        exp_done = (ph_n == 2);
        exp_seq  = 8'(m_seq);
        exp_ovf  = m_sovf;
        exp_rd   = rd_n;
    endfunction

    always @(posedge clk) begin
        if (!key_restart) begin
            model_clear();
            cyc++;
        end else begin
            model_step();
        end
    end

    always @(negedge key_restart) model_clear();

    // ---------------- per-cycle scoreboard compare ----------------
    always @(negedge clk) begin
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        check("seq_no", seq_no, exp_seq);
        check("ovf", ovf, exp_ovf);
        check("rd_data", rd_data, exp_rd);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int len, input bit rep, output int s);
        s           = cyc;
        gate_len    = GATE_W'(len);
        repeat_mode = rep;
        start       = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulses(input int ch, input int n);
        repeat (n) begin
            cnt_in[ch] = 1'b1;
            tick(2);
            cnt_in[ch] = 1'b0;
            tick(2);
        end
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (done) begin
                at = cyc;
                break;
            end
        end
        check("done_seen", (at >= 0), 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int s;
        int d;
        int nd;
        int ndone;
        int prev_d;
        bit fin;

        key_restart = 1'b0;
        cnt_in      = '0;
        gate_len    = '0;
        repeat_mode = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        rd_ch       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, 2'd0);
        key_restart = 1'b1;
        tick(2);

        // single-shot gate of 100 with 10 edges on ch0, none on the last channel
        do_start(100, 1'b0, s);
        pulses(0, 10);
        wait_done(200, d);
        check("t2_done_latency", d - s, 101);
        tick(1);
        check("t2_busy_fall", busy, 0);
        check("t2_seq", seq_no, 1);
        tick(1);
        check("t2_snap0", rd_data, 10);
        rd_ch = 5'(N_CH - 1);
        tick(2);
        check("t2_snap_last", rd_data, 0);
        rd_ch = 0;
        tick(1);

        // asynchronous reset in the middle of a gate
        do_start(100, 1'b0, s);
        pulses(2, 3);
        key_restart = 1'b0;
        #1;
        check("t1_busy", busy, 0);
        check("t1_done", done, 0);
        check("t1_seq", seq_no, 0);
        check("t1_ovf", ovf, 0);
        check("t1_rd", rd_data, 0);
        check("t1_state", state_dbg, 2'd0);
        tick(2);
        key_restart = 1'b1;
        tick(2);
        do_start(8, 1'b0, s);
        pulses(4, 1);
        wait_done(30, d);
        check("t1_restart_latency", d - s, 9);
        rd_ch = 4;
        tick(2);
        check("t1_restart_snap", rd_data, 1);

        // zero gate length acts as one cycle
        do_start(0, 1'b0, s);
        wait_done(10, d);
        check("len0_latency", d - s, 2);
        tick(2);
        check("len0_seq", seq_no, 2);

        // saturation and overflow flag, then recovery on the next gate
        rd_ch = 5;
        do_start(100, 1'b0, s);
        pulses(5, 20);
        wait_done(200, d);
        tick(2);
        check("t3_sat", rd_data, 15);
        check("t3_ovf", ovf, 24'h000020);
        do_start(100, 1'b0, s);
        pulses(5, 2);
        wait_done(200, d);
        tick(2);
        check("t3_recover", rd_data, 2);
        check("t3_ovf_clear", ovf, 0);
        check("t3_seq", seq_no, 4);

        // auto-repeat, quarter-rate clock on ch3, 256 gates
        rd_ch  = 3;
        s      = cyc;
        ndone  = 0;
        prev_d = s;
        d      = -100;
        fin    = 1'b0;
        for (int k = 0; k < 256 * 51 + 60 && !fin; k++) begin
            if (k > 0 && done) begin
                check("t4_period", cyc - prev_d, 51);
                prev_d = cyc;
                d      = cyc;
                ndone++;
            end
            if (cyc == d + 2) check("t4_count_range", (rd_data == 12 || rd_data == 13), 1);
            if (ndone == 256 && cyc == d + 3) check("t4_seq_wrap", seq_no, 4);
            cnt_in[3]   = ((k / 2) % 2 == 0);
            gate_len    = 50;
            repeat_mode = 1'b1;
            start       = (k == 0);
            stop        = (ndone == 256 && cyc == d + 5);
            if (ndone == 256 && cyc == d + 6) fin = 1'b1;
            tick(1);
        end
        check("t4_gates", ndone, 256);
        cnt_in[3] = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        tick(4);
        check("t4_stopped", busy, 0);

        // stop in the 30th cycle of a 100-cycle gate
        do_start(100, 1'b0, s);
        pulses(7, 3);
        tick(17);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("t5_busy_after_stop", busy, 0);
        check("t5_state_after_stop", state_dbg, 2'd0);
        nd = 0;
        for (int i = 0; i < 110; i++) begin
            tick(1);
            if (done) nd++;
        end
        check("t5_no_done", nd, 0);
        check("t5_seq_kept", seq_no, 4);
        gate_len = 5;
        start    = 1'b1;
        stop     = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        check("t5_start_stop_state", state_dbg, 2'd0);
        tick(1);
        check("t5_start_stop_busy", busy, 0);

        // edge landing exactly in the LATCH cycle of a repeating gate
        s = cyc;
        for (int k = 0; k <= 47; k++) begin
            if (k == 23) check("t6_first_gate", rd_data, 2);
            if (k == 44) check("t6_second_gate", rd_data, 1);
            gate_len    = 20;
            repeat_mode = 1'b1;
            start       = (k == 0);
            stop        = (k == 45);
            rd_ch       = 1;
            cnt_in[1]   = (k == 2 || k == 3 || k == 6 || k == 7 ||
                           k == 19 || k == 20 || k == 25 || k == 26);
            tick(1);
        end
        start = 1'b0;
        stop  = 1'b0;
        check("t6_seq", seq_no, 6);
        check("t6_busy", busy, 0);
        rd_ch = 5'(N_CH);
        tick(2);
        check("t6_rd_out_of_range", rd_data, 0);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
